led_pattern_checker: RTL and testbench

Synthesizable monitor for the board's 8-bit running-light LED bus: it samples the LED bus driven by the LED pattern generator, checks that the pattern is a one-hot value rotating left by one position every CNT_MAX clock cycles, and reports lock, per-event errors and running counts. It sits beside the LED driver, on the FPGA or in the bench, as the receiving end of the LED interface, and needs no knowledge of the driver's internals.

---
 rtl/led_pattern_checker.sv | 87 ++++++++
 tb/tb_led_pattern_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_checker.sv
// led_pattern_checker: verifies a one-hot LED bus rotates left exactly every CNT_MAX cycles
module led_pattern_checker #(
  parameter int CNT_MAX = 10,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] led_in,
  output logic             locked,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [15:0]      err_count,
  output logic [15:0]      step_count
);
  localparam int HW = $clog2(CNT_MAX + 2);
  localparam logic [HW-1:0] HOLD  = HW'(CNT_MAX);
  localparam logic [HW-1:0] STUCK = HW'(CNT_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, VERIFY, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d, led_p_q, led_p_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic             locked_q, locked_d, error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [15:0]      err_count_q, err_count_d, step_count_q, step_count_d;
  logic             chg, legal;
  // sample the bus, time the hold, and judge each step in the active states
  always_comb begin
    led_d = led_in;
    led_p_d = led_q;
    chg = led_q != led_p_q;
    legal = chg && led_q == {led_p_q[WIDTH-2:0], led_p_q[WIDTH-1]} && $onehot(led_p_q);
    hcnt_d = chg ? HW'(1) : hcnt_q == STUCK ? hcnt_q : hcnt_q + HW'(1);
    state_d = state_q;
    error_d = 1'b0;
    err_code_d = err_code_q;
    step_count_d = step_count_q;
    if (!en) state_d = IDLE;
    else if (state_q == IDLE) state_d = ACQUIRE;
    else if (state_q == ACQUIRE) state_d = legal ? VERIFY : ACQUIRE;
    else if (chg && !legal) begin
      error_d = 1'b1;
      err_code_d = 2'd1;
    end else if (chg && hcnt_q < HOLD) begin
      error_d = 1'b1;
      err_code_d = 2'd2;
    end else if (chg && hcnt_q == HOLD) begin
      step_count_d = step_count_q + 16'd1;
      state_d = LOCKED;
    end else if (!chg && hcnt_q == STUCK) begin
      error_d = 1'b1;
      err_code_d = 2'd3;
    end
    if (error_d) state_d = ACQUIRE;
    err_count_d = (error_d && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    locked_d = state_d == LOCKED;
  end
  // register all state; reset wins over every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      led_p_q <= '0;
      hcnt_q <= '0;
      state_q <= IDLE;
      locked_q <= 1'b0;
      error_q <= 1'b0;
      err_code_q <= 2'd0;
      err_count_q <= 16'd0;
      step_count_q <= 16'd0;
    end else begin
      led_q <= led_d;
      led_p_q <= led_p_d;
      hcnt_q <= hcnt_d;
      state_q <= state_d;
      locked_q <= locked_d;
      error_q <= error_d;
      err_code_q <= err_code_d;
      err_count_q <= err_count_d;
      step_count_q <= step_count_d;
    end
  end
  assign locked = locked_q;
  assign error = error_q;
  assign err_code = err_code_q;
  assign err_count = err_count_q;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_led_pattern_checker.sv
// tb_led_pattern_checker: directed and random bus traffic checked against a timestamp-based model
module tb_led_pattern_checker;
  localparam int CNT_MAX = 10;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, en;
  logic [W-1:0] led_in;
  logic locked, error;
  logic [1:0] err_code;
  logic [15:0] err_count, step_count;
  int checks = 0, errors = 0;
  int cyc = 0, m_last = 0, m_prev = 0, m_mode = 0, m_ecnt = 0, m_scnt = 0;
  logic [W-1:0] m_lq = '0, m_lp = '0, cur = '0, prev_v;
  logic m_err = 1'b0;
  logic [1:0] m_code = 2'd0;
  int pulses, first_err, a, ss, es;

  led_pattern_checker #(.CNT_MAX(CNT_MAX), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .led_in(led_in), .locked(locked), .error(error),
    .err_code(err_code), .err_count(err_count), .step_count(step_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
    return (x << 1) | (x >> (W - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 idle, 1 acquire, 2 verify, 3 locked; hold lengths come from change timestamps
  task automatic model(input logic r, input logic e, input logic [W-1:0] v);
    logic chg, legal;
    int hold, held;
    cyc++;
    m_err = 1'b0;
    if (r) begin
      m_lq = '0; m_lp = '0; m_last = cyc; m_prev = cyc;
      m_mode = 0; m_code = 2'd0; m_ecnt = 0; m_scnt = 0;
    end else begin
      chg = m_lq != m_lp;
      legal = chg && m_lq == rotl(m_lp) && $countones(m_lp) == 1;
      hold = m_last - m_prev;
      held = cyc - 1 - m_last;
      if (!e) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin if (legal) m_mode = 2; end
      else if (chg && !legal) begin m_err = 1'b1; m_code = 2'd1; end
      else if (chg && hold < CNT_MAX) begin m_err = 1'b1; m_code = 2'd2; end
      else if (chg && hold == CNT_MAX) begin m_scnt = (m_scnt + 1) % 65536; m_mode = 3; end
      else if (!chg && held > CNT_MAX) begin m_err = 1'b1; m_code = 2'd3; end
      if (m_err) begin
        m_mode = 1;
        if (m_ecnt < 65535) m_ecnt++;
      end
      if (v != m_lq) begin m_prev = m_last; m_last = cyc; end
      m_lp = m_lq;
      m_lq = v;
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic [W-1:0] v);
    rst = r; en = e; led_in = v;
    @(posedge clk);
    model(r, e, v);
    #1;
    chk("locked", locked, 32'(m_mode == 3));
    chk("error", error, 32'(m_err));
    chk("err_code", err_code, 32'(m_code));
    chk("err_count", err_count, m_ecnt);
    chk("step_count", step_count, m_scnt);
  endtask

  task automatic run(input logic [W-1:0] v, input int n);
    cur = v;
    repeat (n) tick(1'b0, 1'b1, v);
  endtask

  task automatic good(input int n);
    run(rotl(cur), n);
  endtask

  initial begin
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    // good pattern 01..80 and wrap back to 04
    run(8'h01, CNT_MAX);
    repeat (10) good(CNT_MAX);
    chk("good_locked", locked, 1);
    chk("good_steps", step_count, 9);
    chk("good_errs", err_count, 0);
    // early step
    good(7);
    good(CNT_MAX);
    chk("early_code", err_code, 2);
    chk("early_errs", err_count, 1);
    repeat (3) good(CNT_MAX);
    chk("early_relock", locked, 1);
    // multi-hot destination
    prev_v = cur;
    run(prev_v | rotl(prev_v), CNT_MAX);
    chk("mh_code", err_code, 1);
    chk("mh_errs", err_count, 2);
    cur = rotl(prev_v);
    repeat (3) good(CNT_MAX);
    // skipped position
    prev_v = cur;
    run(rotl(rotl(prev_v)), CNT_MAX);
    chk("skip_code", err_code, 1);
    chk("skip_errs", err_count, 3);
    repeat (3) good(CNT_MAX);
    chk("skip_relock", locked, 1);
    // stuck bus
    pulses = 0;
    first_err = 0;
    cur = rotl(cur);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 1'b1, cur);
      if (error) begin
        pulses++;
        if (first_err == 0) first_err = i;
      end
    end
    chk("stuck_pulses", pulses, 1);
    chk("stuck_at", first_err, 13);
    chk("stuck_code", err_code, 3);
    repeat (3) good(CNT_MAX);
    chk("stuck_relock", locked, 1);
    // reset mid-lock
    tick(1'b1, 1'b1, cur);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_error", error, 0);
    chk("rst_mid_code", err_code, 0);
    chk("rst_mid_errs", err_count, 0);
    chk("rst_mid_steps", step_count, 0);
    repeat (4) good(CNT_MAX);
    chk("rst_relock", locked, 1);
    // enable drop mid-lock
    ss = m_scnt;
    es = m_ecnt;
    tick(1'b0, 1'b0, cur);
    chk("en_locked", locked, 0);
    chk("en_steps", step_count, ss);
    chk("en_errs", err_count, es);
    // random traffic
    for (int s = 0; s < 300; s++) begin
      a = $urandom_range(0, 99);
      if (a < 65) good(CNT_MAX);
      else if (a < 78) good($urandom_range(1, CNT_MAX + 3));
      else if (a < 86) run(W'($urandom), $urandom_range(1, 12));
      else if (a < 93) repeat ($urandom_range(1, 4)) tick(1'b0, 1'b0, cur);
      else if (a < 96) tick(1'b1, 1'($urandom_range(0, 1)), cur);
      else good($urandom_range(CNT_MAX + 1, CNT_MAX + 14));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
